jtopl_wrarb: RTL

Write arbiter and sequencer for the jtopl CPU port. Two requesters (typically the host CPU and a register-replay/init engine) post complete register writes as one (register, data) pair. The block arbitrates between them round-robin and drives the two-step OPL bus cycle: an address write, then a data write, each followed by a programmable wait in cen ticks. Its outputs connect directly to jtopl din/addr/cs_n/wr_n, and it is the only driver of that port.

---
 rtl/jtopl_wrarb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/jtopl_wrarb.sv
// rtl/jtopl_wrarb.sv - round-robin write arbiter and OPL bus cycle sequencer for jtopl
module jtopl_wrarb #(
   parameter int ADDR_WAIT = 12,
   parameter int DATA_WAIT = 84
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       a_req,
   input  logic [7:0] a_reg,
   input  logic [7:0] a_data,
   output logic       a_ack,
   input  logic       b_req,
   input  logic [7:0] b_reg,
   input  logic [7:0] b_data,
   output logic       b_ack,
   output logic [7:0] opl_din,
   output logic       opl_addr,
   output logic       opl_cs_n,
   output logic       opl_wr_n,
   output logic       busy
);

   localparam logic [7:0] AW = 8'(ADDR_WAIT);
   localparam logic [7:0] DW = 8'(DATA_WAIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_AWAIT,
      S_DATA,
      S_DWAIT
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] lat_reg, lat_data, reg_nxt, data_nxt;
   logic       prefer_b, prefer_b_nxt;
   logic       grant_a, grant_b;
   logic       strobe_n, strobe_n_nxt;
   logic       addr_nxt;
   logic [7:0] din_nxt;

   // Next-state, arbitration and next bus value; the bus value is derived from
   // the next state so the registered outputs line up with the state they belong to.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      reg_nxt      = lat_reg;
      data_nxt     = lat_data;
      prefer_b_nxt = prefer_b;
      grant_a      = 1'b0;
      grant_b      = 1'b0;
      strobe_n_nxt = 1'b1;
      addr_nxt     = 1'b0;
      din_nxt      = 8'h00;

      case (state)
         S_IDLE: begin
            // B wins a tie only when A was the last one served
            if (a_req && (!b_req || !prefer_b)) begin
               grant_a      = 1'b1;
               reg_nxt      = a_reg;
               data_nxt     = a_data;
               prefer_b_nxt = 1'b1;
               state_nxt    = S_ADDR;
            end else if (b_req) begin
               grant_b      = 1'b1;
               reg_nxt      = b_reg;
               data_nxt     = b_data;
               prefer_b_nxt = 1'b0;
               state_nxt    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (AW == 8'd0) begin
               state_nxt = S_DATA;
            end else begin
               state_nxt = S_AWAIT;
               cnt_nxt   = AW;
            end
         end
         S_AWAIT: begin
            if (cnt <= 8'd1) state_nxt = S_DATA;
            else             cnt_nxt   = cnt - 8'd1;
         end
         S_DATA: begin
            if (DW == 8'd0) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_DWAIT;
               cnt_nxt   = DW;
            end
         end
         S_DWAIT: begin
            if (cnt <= 8'd1) state_nxt = S_IDLE;
            else             cnt_nxt   = cnt - 8'd1;
         end
         default: state_nxt = S_IDLE;
      endcase

      case (state_nxt)
         S_ADDR: begin
            strobe_n_nxt = 1'b0;
            din_nxt      = reg_nxt;
         end
         S_DATA: begin
            strobe_n_nxt = 1'b0;
            addr_nxt     = 1'b1;
            din_nxt      = data_nxt;
         end
         default: ;
      endcase
   end

   // State and bus registers advance on cen; acks are single-clk pulses independent of cen
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 8'd0;
         lat_reg  <= 8'h00;
         lat_data <= 8'h00;
         prefer_b <= 1'b0;
         strobe_n <= 1'b1;
         opl_addr <= 1'b0;
         opl_din  <= 8'h00;
         a_ack    <= 1'b0;
         b_ack    <= 1'b0;
      end else begin
         a_ack <= cen && grant_a;
         b_ack <= cen && grant_b;
         if (cen) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lat_reg  <= reg_nxt;
            lat_data <= data_nxt;
            prefer_b <= prefer_b_nxt;
            strobe_n <= strobe_n_nxt;
            opl_addr <= addr_nxt;
            opl_din  <= din_nxt;
         end
      end
   end

   assign opl_cs_n = strobe_n;
   assign opl_wr_n = strobe_n;
   assign busy     = (state != S_IDLE);

endmodule
